pic_cpu_ack_master: RTL and testbench
=====================================

Name: pic_cpu_ack_master

Overview:
CPU-side counterpart of the 8259 PIC in-service logic. It watches the PIC's INT line and runs the two-pulse INTA acknowledge sequence that sets and, in AEOI mode, clears ISR bits in the PIC. It captures the vector byte the PIC drives on the second pulse. On core request it issues the OCW2 End-Of-Interrupt write, non-specific or specific, that clears ISR bits in normal-EOI mode. The block sits between the processor core/testbench and the PIC bus pins.

Parameters:
PULSE_CYCLES, 2, clocks each INTA pulse is held low (1..15)
GAP_CYCLES, 2, clocks inta_n is held high between the two pulses (1..15)
WR_CYCLES, 2, clocks wr_n is held low during the EOI write (1..15)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
int_req  in  1  INT from PIC; asynchronous, passed through an internal 2-FF synchroniser
ack_enable  in  1  core interrupt-enable (IF); an acknowledge starts only while high
data_in  in  8  PIC data bus, read during the second INTA pulse
inta_n  out  1  INTA to PIC, active low
vector  out  8  last captured vector; holds until the next capture
vector_valid  out  1  one-cycle pulse when vector updates
eoi_req  in  1  request an EOI write; sampled every cycle
eoi_specific  in  1  with eoi_req: 1 = specific EOI, 0 = non-specific
eoi_level  in  3  IR level for a specific EOI
eoi_done  out  1  one-cycle pulse when the EOI write completes
cs_n  out  1  PIC chip select, active low
wr_n  out  1  PIC write strobe, active low
a0  out  1  PIC address bit; always 0 (OCW2)
data_out  out  8  EOI command byte
data_oe  out  1  data_out drive enable
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset, including mid-operation: state returns to IDLE and the synchroniser flops, pending-EOI latch and counter are cleared.
- Reset output values: inta_n=1, cs_n=1, wr_n=1, a0=0, data_out=0, data_oe=0, vector=0, vector_valid=0, eoi_done=0, busy=0.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- EOI latch:
  - When eoi_req=1 and no EOI is pending, the latch captures eoi_specific and eoi_level and sets pending.
  - Pending clears when eoi_done pulses.
  - eoi_req while pending is ignored; one EOI is outstanding at a time.
- States: IDLE, ACK1, GAP, ACK2, VEC, EOI_SETUP, EOI_WR, EOI_HOLD.
- A 4-bit down counter times ACK1, GAP, ACK2 and EOI_WR.
- IDLE:
  - pending EOI -> EOI_SETUP. EOI has priority over an acknowledge when both are eligible in the same cycle.
  - Else int_sync=1 and ack_enable=1 -> ACK1.
  - Latency: if edge 1 is the first edge sampling int_req high, int_sync is high after edge 2 and inta_n is low after edge 3.
- ACK1: inta_n=0 for PULSE_CYCLES clocks -> GAP.
- GAP: inta_n=1 for GAP_CYCLES clocks -> ACK2.
- ACK2:
  - inta_n=0 for PULSE_CYCLES clocks.
  - data_in is registered into vector on the final ACK2 cycle -> VEC.
- VEC: vector_valid=1 for exactly one cycle -> IDLE.
- Sequence completion:
  - The sequence always completes once started, even if int_req or ack_enable drops mid-sequence.
  - The PIC returns its spurious vector in that case; the block does not filter it.
- Re-acknowledge: the core must drop ack_enable after vector_valid to prevent re-acknowledging the same request. The block does not otherwise inhibit re-entry.
- EOI_SETUP:
  - 1 cycle: cs_n=0, a0=0, data_oe=1, wr_n=1.
  - data_out = 8'h20 when the latched eoi_specific=0.
  - data_out = {5'b01100, eoi_level} (8'h60 | level) when eoi_specific=1.
- EOI_WR: wr_n=0 for WR_CYCLES clocks; cs_n, data_out and data_oe held.
- EOI_HOLD:
  - 1 cycle with wr_n=1; cs_n, data_out and data_oe held.
  - The next edge deasserts cs_n and data_oe, clears data_out to 0, pulses eoi_done for one cycle and returns to IDLE.
- An EOI requested during an acknowledge is serviced immediately after VEC, before any new acknowledge.
- busy=1 from the cycle after leaving IDLE until the cycle that returns to IDLE. busy is low during the eoi_done and vector_valid cycles only if the state is already IDLE; decode busy strictly from state.

Test Plan (PULSE_CYCLES=2, GAP_CYCLES=2, WR_CYCLES=2):
1. int_req=1, ack_enable=1, data_in=8'h4B during ACK2 -> inta_n low 2, high 2, low 2 cycles starting after edge 3; vector=8'h4B with a single vector_valid pulse on the cycle after ACK2; ISR-set and AEOI timing match the PIC model.
2. IDLE, eoi_req=1, eoi_specific=1, eoi_level=3'd5 -> data_out=8'h65, a0=0, cs_n low 4 cycles, wr_n low exactly 2 cycles inside cs_n, then eoi_done pulses once; with eoi_specific=0 -> data_out=8'h20.
3. int_req and eoi_req both asserted while IDLE with int_sync already high -> EOI write completes first (eoi_done), then the INTA sequence starts.
4. eoi_req pulsed during GAP -> no cs_n activity until after vector_valid; then the EOI write runs with the values latched during GAP.
5. reset asserted during ACK2 -> after that edge inta_n=1 and busy=0, no vector_valid, vector unchanged; a subsequent int_req restarts cleanly from ACK1.
6. ack_enable=0 with int_req=1 for 20 cycles -> inta_n stays 1; raising ack_enable starts ACK1 on the next edge.

Source files
------------

// File: rtl/pic_cpu_ack_master.sv
// rtl/pic_cpu_ack_master.sv - CPU-side INTA acknowledge and OCW2 EOI master for an 8259 PIC
module pic_cpu_ack_master #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int WR_CYCLES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       int_req,
  input  logic       ack_enable,
  input  logic [7:0] data_in,
  output logic       inta_n,
  output logic [7:0] vector,
  output logic       vector_valid,
  input  logic       eoi_req,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  output logic       eoi_done,
  output logic       cs_n,
  output logic       wr_n,
  output logic       a0,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       busy
);

  // Counter reloads: each timed state lasts (reload + 1) clocks.
  localparam logic [3:0] PULSE_M1 = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_M1   = 4'(GAP_CYCLES - 1);
  localparam logic [3:0] WR_M1    = 4'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ACK1, GAP, ACK2, VEC, EOI_SETUP, EOI_WR, EOI_HOLD
  } state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic       sync1_q, sync2_q;
  logic       eoi_pend_q, eoi_spec_q;
  logic [2:0] eoi_lvl_q;
  logic       inta_n_q, vector_valid_q, eoi_done_q;
  logic       cs_n_q, wr_n_q, data_oe_q;
  logic [7:0] vector_q, data_out_q;

  // Two-flop synchroniser for the asynchronous INT line.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= int_req;
      sync2_q <= sync1_q;
    end
  end

  // Main sequencer: INTA pulse pair, vector capture, EOI write, plus the EOI request latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      eoi_pend_q     <= 1'b0;
      eoi_spec_q     <= 1'b0;
      eoi_lvl_q      <= 3'd0;
      inta_n_q       <= 1'b1;
      vector_q       <= 8'h00;
      vector_valid_q <= 1'b0;
      eoi_done_q     <= 1'b0;
      cs_n_q         <= 1'b1;
      wr_n_q         <= 1'b1;
      data_oe_q      <= 1'b0;
      data_out_q     <= 8'h00;
    end else begin
      // Only one EOI may be outstanding; later requests are dropped until it completes.
      if (!eoi_pend_q && eoi_req) begin
        eoi_pend_q <= 1'b1;
        eoi_spec_q <= eoi_specific;
        eoi_lvl_q  <= eoi_level;
      end

      case (state_q)
        IDLE: begin
          vector_valid_q <= 1'b0;
          eoi_done_q     <= 1'b0;
          if (eoi_pend_q) begin
            state_q    <= EOI_SETUP;
            cs_n_q     <= 1'b0;
            data_oe_q  <= 1'b1;
            data_out_q <= eoi_spec_q ? {5'b01100, eoi_lvl_q} : 8'h20;
          end else if (sync2_q && ack_enable) begin
            state_q  <= ACK1;
            inta_n_q <= 1'b0;
            cnt_q    <= PULSE_M1;
          end
        end
        ACK1: begin
          if (cnt_q == 4'd0) begin
            state_q  <= GAP;
            inta_n_q <= 1'b1;
            cnt_q    <= GAP_M1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        GAP: begin
          if (cnt_q == 4'd0) begin
            state_q  <= ACK2;
            inta_n_q <= 1'b0;
            cnt_q    <= PULSE_M1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ACK2: begin
          // The PIC drives the vector during the second pulse; sample on its last cycle.
          if (cnt_q == 4'd0) begin
            state_q        <= VEC;
            inta_n_q       <= 1'b1;
            vector_q       <= data_in;
            vector_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        VEC: begin
          state_q        <= IDLE;
          vector_valid_q <= 1'b0;
        end
        EOI_SETUP: begin
          state_q <= EOI_WR;
          wr_n_q  <= 1'b0;
          cnt_q   <= WR_M1;
        end
        EOI_WR: begin
          if (cnt_q == 4'd0) begin
            state_q <= EOI_HOLD;
            wr_n_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        EOI_HOLD: begin
          state_q    <= IDLE;
          cs_n_q     <= 1'b1;
          data_oe_q  <= 1'b0;
          data_out_q <= 8'h00;
          eoi_done_q <= 1'b1;
          eoi_pend_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inta_n       = inta_n_q;
  assign vector       = vector_q;
  assign vector_valid = vector_valid_q;
  assign eoi_done     = eoi_done_q;
  assign cs_n         = cs_n_q;
  assign wr_n         = wr_n_q;
  assign a0           = 1'b0;
  assign data_out     = data_out_q;
  assign data_oe      = data_oe_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_pic_cpu_ack_master.sv
// tb/tb_pic_cpu_ack_master.sv - directed vector bench for pic_cpu_ack_master
module tb_pic_cpu_ack_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       int_req = 1'b0;
  logic       ack_enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       eoi_req = 1'b0;
  logic       eoi_specific = 1'b0;
  logic [2:0] eoi_level = 3'd0;
  logic       inta_n, vector_valid, eoi_done, cs_n, wr_n, a0, data_oe, busy;
  logic [7:0] vector, data_out;

  int checks = 0;
  int errors = 0;

  pic_cpu_ack_master #(.PULSE_CYCLES(2), .GAP_CYCLES(2), .WR_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .int_req(int_req), .ack_enable(ack_enable),
    .data_in(data_in), .inta_n(inta_n), .vector(vector), .vector_valid(vector_valid),
    .eoi_req(eoi_req), .eoi_specific(eoi_specific), .eoi_level(eoi_level),
    .eoi_done(eoi_done), .cs_n(cs_n), .wr_n(wr_n), .a0(a0), .data_out(data_out),
    .data_oe(data_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, irq, ack, eoi, spec;
    logic [2:0] lvl;
    logic       x_inta, x_vv;
    logic [7:0] x_vec;
    logic       x_cs, x_wr, x_oe;
    logic [7:0] x_dout;
    logic       x_done, x_busy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic irq, logic ack, logic eoi, logic spec,
                              logic [2:0] lvl, logic inta, logic vv, logic [7:0] vec,
                              logic cs, logic wr, logic oe, logic [7:0] dout,
                              logic done, logic bsy);
    vec_t v;
    v.rst = rst; v.irq = irq; v.ack = ack; v.eoi = eoi; v.spec = spec; v.lvl = lvl;
    v.x_inta = inta; v.x_vv = vv; v.x_vec = vec; v.x_cs = cs; v.x_wr = wr;
    v.x_oe = oe; v.x_dout = dout; v.x_done = done; v.x_busy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  n;
    int  lows;
    bit  seen;
    bit  early;

    // Cycle trace: acknowledge with vector 4B, then specific EOI level 5, then non-specific EOI.
    //            rst irq ack eoi spc lvl  inta vv vec   cs wr oe dout  done busy
    tbl.push_back(mk(1, 0, 0, 0, 0, 3'd0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd0, 1, 0, 8'h00, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 1, 8'h4B, 1, 1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h4B, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 3'd5, 1, 0, 8'h4B, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h4B, 0, 1, 1, 8'h65, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h4B, 0, 0, 1, 8'h65, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h4B, 0, 0, 1, 8'h65, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h4B, 0, 1, 1, 8'h65, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h4B, 1, 1, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h4B, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 3'd7, 1, 0, 8'h4B, 1, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h4B, 0, 1, 1, 8'h20, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h4B, 0, 0, 1, 8'h20, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h4B, 0, 0, 1, 8'h20, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h4B, 0, 1, 1, 8'h20, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h4B, 1, 1, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 1, 0, 8'h4B, 1, 1, 0, 8'h00, 0, 0));

    data_in = 8'h4B;
    foreach (tbl[i]) begin
      reset = tbl[i].rst; int_req = tbl[i].irq; ack_enable = tbl[i].ack;
      eoi_req = tbl[i].eoi; eoi_specific = tbl[i].spec; eoi_level = tbl[i].lvl;
      step();
      chk($sformatf("vec%0d", i),
          {8'h0, inta_n, vector_valid, vector, cs_n, wr_n, a0, data_oe, data_out, eoi_done, busy},
          {8'h0, tbl[i].x_inta, tbl[i].x_vv, tbl[i].x_vec, tbl[i].x_cs, tbl[i].x_wr, 1'b0,
           tbl[i].x_oe, tbl[i].x_dout, tbl[i].x_done, tbl[i].x_busy});
    end
    eoi_req = 1'b0;

    // EOI wins over an acknowledge when both are eligible in IDLE.
    int_req = 1'b1; ack_enable = 1'b0; data_in = 8'h31;
    repeat (4) step();
    chk("t3_idle_inta", inta_n, 1);
    eoi_req = 1'b1; eoi_specific = 1'b0;
    step();
    eoi_req = 1'b0; ack_enable = 1'b1;
    step();
    chk("t3_eoi_first_cs", cs_n, 0);
    chk("t3_eoi_first_inta", inta_n, 1);
    seen = 0; early = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (inta_n == 1'b0) early = 1;
      step();
      if (eoi_done) seen = 1;
    end
    chk("t3_eoi_done_seen", seen, 1);
    chk("t3_no_inta_before_done", early, 0);
    step();
    chk("t3_ack_after_eoi", inta_n, 0);
    ack_enable = 1'b0; int_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (vector_valid) seen = 1;
    end
    chk("t3_vv_seen", seen, 1);
    chk("t3_vector", vector, 8'h31);

    // EOI requested during GAP is held until after the vector, with GAP-time values.
    step();
    int_req = 1'b1; ack_enable = 1'b1; data_in = 8'h5C;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (!inta_n) seen = 1;
    end
    chk("t4_ack1_seen", seen, 1);
    step(); step();
    chk("t4_in_gap", {inta_n, busy}, 2'b11);
    eoi_req = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd2;
    step();
    eoi_req = 1'b0; eoi_specific = 1'b0; eoi_level = 3'd7;
    ack_enable = 1'b0; int_req = 1'b0;
    seen = 0; early = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (!cs_n) early = 1;
      step();
      if (vector_valid) seen = 1;
    end
    chk("t4_vv_seen", seen, 1);
    chk("t4_no_cs_before_vv", early, 0);
    chk("t4_vector", vector, 8'h5C);
    n = 0;
    for (int k = 0; k < 10 && cs_n; k++) begin
      step();
      n++;
    end
    chk("t4_cycles_vv_to_cs", n, 2);
    chk("t4_latched_cmd", data_out, 8'h62);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (eoi_done) seen = 1;
    end
    chk("t4_eoi_done_seen", seen, 1);

    // Reset during ACK2 aborts cleanly; a fresh request restarts from ACK1.
    reset = 1'b1;
    step();
    reset = 1'b0; int_req = 1'b1; ack_enable = 1'b1; data_in = 8'hAA;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (!inta_n) seen = 1;
    end
    chk("t5_ack1_seen", seen, 1);
    repeat (4) step();
    chk("t5_in_ack2", {inta_n, busy}, 2'b01);
    reset = 1'b1;
    step();
    chk("t5_reset_outs", {inta_n, busy, vector_valid, vector}, {3'b100, 8'h00});
    reset = 1'b0; data_in = 8'h3C;
    step(); step();
    chk("t5_sync_refill", inta_n, 1);
    step();
    chk("t5_restart_ack1", {inta_n, busy}, 2'b01);
    ack_enable = 1'b0; int_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (vector_valid) seen = 1;
    end
    chk("t5_vv_seen", seen, 1);
    chk("t5_vector", vector, 8'h3C);
    step();

    // ack_enable gates the start of an acknowledge.
    int_req = 1'b1; ack_enable = 1'b0;
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!inta_n) lows++;
    end
    chk("t6_inta_gated", lows, 0);
    chk("t6_idle_busy", busy, 0);
    ack_enable = 1'b1;
    step();
    chk("t6_ack1_next_edge", inta_n, 0);
    ack_enable = 1'b0; int_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      if (vector_valid) seen = 1;
    end
    chk("t6_vv_seen", seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
